argon_alu_seq: RTL and testbench
================================

Name: argon_alu_seq

Overview:
- Parametrised next-generation Argon ALU: WIDTH-bit datapath with a valid/ready request/response handshake instead of per-register latch strobes.
- Adds signed flags (negative, overflow), a barrel shift with carry-out, and an optional iterative multiplier.
- Sits between the control unit and the register file; the control unit issues one operation per request and consumes one result per response.

Parameters:
WIDTH, 16, datapath width in bits (min 4, power of two)
SHW, $clog2(WIDTH), shift-amount bits taken from i_b (derived; do not override)

Ports:
i_Clk  in  1  clock, rising edge
i_Reset_n  in  1  asynchronous active-low reset
i_valid  in  1  request valid
o_ready  out  1  request can be accepted
i_op  in  4  opcode
i_a  in  WIDTH  operand A
i_b  in  WIDTH  operand B
i_flags_we  in  1  write flag register from i_flags
i_flags  in  8  flag write data
o_valid  out  1  result valid
i_ready  in  1  result consumed
o_y  out  WIDTH  result
o_flags  out  8  flag register: [0]C [1]Z [2]EQ [3]GT [4]LT [5]N [6]V [7]reserved, reads 0

Behaviour:
- Opcodes: 0 ADD, 1 ADC, 2 SBC, 3 INC, 4 DEC, 5 NAND, 6 AND, 7 OR, 8 NOR, 9 XOR, A LSH, B RSH, C CMP, D MUL, E-F reserved.
- Reset: state IDLE, o_valid=0, o_y=0, o_flags=0, multiplier registers 0. Reset mid-operation aborts the operation; no result is produced.
- FSM IDLE -> (accept, non-MUL) DONE; IDLE -> (accept, MUL) BUSY; BUSY -> (WIDTH iterations complete) DONE; DONE -> (o_valid && i_ready) IDLE.
- o_ready = (state==IDLE) && !i_flags_we. Accept = i_valid && o_ready. Operands and opcode are registered at accept; inputs are don't-care afterwards.
- Flag write: in IDLE, i_flags_we writes i_flags[6:0] into the flag register and blocks acceptance that cycle. In BUSY/DONE, i_flags_we is ignored.
- Latency: non-MUL result is valid the cycle after accept. MUL result is valid WIDTH+1 cycles after accept.
- In DONE, o_y and o_flags are held stable until the handshake completes. No new request is accepted before the result is consumed.
- Arithmetic is computed in WIDTH+1 bits.
  - ADD/ADC/INC: C = bit WIDTH.
  - SBC/DEC: C = borrow. SBC computes A-B-C_in.
  - ADC uses C_in from the flag register as it stands at accept.
- V: signed overflow for ADD/ADC/INC/SBC/DEC; 0 for all other ops.
- N = y[WIDTH-1]; Z = (y==0).
- Logic ops: C=0.
- LSH/RSH: shift by i_b[SHW-1:0]. C = last bit shifted out; 0 when the amount is 0.
- Flag update per op:
  - Arithmetic, logic and shift ops update C, Z, N, V and leave EQ/GT/LT unchanged.
  - CMP: o_y=A-B, C=borrow, Z, N, V. EQ=(A==B); GT/LT are unsigned compares.
  - Reserved ops: o_y=0, flags unchanged, still complete with a response.
- Flag register updates on the transition into DONE.

Optional Feature:
- Macro ARGON_ALU_MUL_EN.
- Defined: MUL is a shift-add iterative multiply taking WIDTH cycles in BUSY.
  - o_y = low WIDTH bits of the product.
  - C = 1 if the high half is nonzero.
  - Z and N are from o_y; V=0.
- Undefined: opcode D behaves as reserved (1-cycle, o_y=0, flags unchanged). BUSY is unreachable and the multiplier logic is not synthesised.

Test Plan:
- WIDTH=16, ADD A=FFFF B=0001 -> o_valid next cycle, o_y=0000, C=1, Z=1, N=0, V=0.
- Flag write C=1, then ADC A=0001 B=0001 -> o_y=0003. Then SBC A=0005 B=0005 with C=0 -> o_y=0000, Z=1, C=0.
- CMP A=0003 B=0007 -> LT=1, GT=0, EQ=0, C=1, N=1. Hold i_ready=0 for 5 cycles -> o_y/o_flags stable, o_ready=0 throughout.
- RSH A=8001 B=0001 -> o_y=4000, C=1. LSH A=8001 B=0010 (amount 0) -> o_y=8001, C=0.
- With ARGON_ALU_MUL_EN: MUL A=0100 B=0100 -> o_valid exactly 17 cycles after accept, o_y=0000, C=1, Z=1. Without the macro -> 1-cycle, o_y=0000, flags unchanged.
- Assert i_Reset_n low during BUSY MUL -> o_valid=0, o_flags=00, o_ready=1 after release. A subsequent ADD completes normally.

Source files
------------

// File: rtl/argon_alu_seq_if.sv
// Request/response bus between the control unit (master) and the Argon ALU (slave).
// The request side carries the operation and flag writes; the response side carries result and flags.
interface argon_alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [3:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_flags_we;
    logic [7:0]       i_flags;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_y;
    logic [7:0]       o_flags;

    modport master (
        output i_valid, i_op, i_a, i_b, i_flags_we, i_flags, i_ready,
        input  o_ready, o_valid, o_y, o_flags
    );

    modport slave (
        input  i_valid, i_op, i_a, i_b, i_flags_we, i_flags, i_ready,
        output o_ready, o_valid, o_y, o_flags
    );
endinterface

// File: rtl/argon_alu_seq.sv
// Argon ALU: WIDTH-bit datapath, valid/ready request and response, C/Z/EQ/GT/LT/N/V flag register.
// Define ARGON_ALU_MUL_EN to build the iterative shift-add multiplier for opcode D.
module argon_alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic           i_Clk,
    input  logic           i_Reset_n,
    argon_alu_seq_if.slave bus,
    output logic [1:0]     o_dbgState
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SBC  = 4'h2;
    localparam logic [3:0] OP_INC  = 4'h3;
    localparam logic [3:0] OP_DEC  = 4'h4;
    localparam logic [3:0] OP_NAND = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_NOR  = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_LSH  = 4'hA;
    localparam logic [3:0] OP_RSH  = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            state;
    logic             validReg;
    logic [WIDTH-1:0] yReg;
    logic [6:0]       flagReg;

    logic             accept;
    logic             goBusy;
    logic             mulDone;
    logic [WIDTH-1:0] mulY;
    logic             mulHi;

    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [SHW-1:0]   shAmt;
    logic [WIDTH:0]   cInExt;
    logic [WIDTH:0]   ext;
    logic [WIDTH:0]   rshTmp;
    logic [WIDTH-1:0] resY;
    logic             resV;
    logic             updNzcv;
    logic             updCmp;
    logic [6:0]       nextFlags;
    logic             unusedFlagBit;

    // Handshake: a request transfers on a cycle where i_valid && o_ready; a response
    // transfers on a cycle where o_valid && i_ready. o_valid/o_y/o_flags hold until then.
    assign bus.o_ready   = (state == IDLE) && !bus.i_flags_we;
    assign accept        = bus.i_valid && bus.o_ready;
    assign bus.o_valid   = validReg;
    assign bus.o_y       = yReg;
    assign bus.o_flags   = {1'b0, flagReg};
    assign o_dbgState    = state;
    assign unusedFlagBit = bus.i_flags[7];

    assign opA    = bus.i_a;
    assign opB    = bus.i_b;
    assign shAmt  = bus.i_b[SHW-1:0];
    assign cInExt = {{WIDTH{1'b0}}, flagReg[0]};
    assign resY   = ext[MSB:0];

    // ext holds {carry/borrow/shifted-out bit, result} for every single-cycle op.
    always_comb begin
        ext     = '0;
        resV    = 1'b0;
        updNzcv = 1'b1;
        updCmp  = 1'b0;
        rshTmp  = {opA, 1'b0} >> shAmt;
        case (bus.i_op)
            OP_ADD: begin
                ext  = {1'b0, opA} + {1'b0, opB};
                resV = (opA[MSB] == opB[MSB]) && (ext[MSB] != opA[MSB]);
            end
            OP_ADC: begin
                ext  = {1'b0, opA} + {1'b0, opB} + cInExt;
                resV = (opA[MSB] == opB[MSB]) && (ext[MSB] != opA[MSB]);
            end
            OP_SBC: begin
                ext  = {1'b0, opA} - {1'b0, opB} - cInExt;
                resV = (opA[MSB] != opB[MSB]) && (ext[MSB] != opA[MSB]);
            end
            OP_INC: begin
                ext  = {1'b0, opA} + ONE;
                resV = !opA[MSB] && ext[MSB];
            end
            OP_DEC: begin
                ext  = {1'b0, opA} - ONE;
                resV = opA[MSB] && !ext[MSB];
            end
            OP_NAND: ext = {1'b0, ~(opA & opB)};
            OP_AND:  ext = {1'b0, opA & opB};
            OP_OR:   ext = {1'b0, opA | opB};
            OP_NOR:  ext = {1'b0, ~(opA | opB)};
            OP_XOR:  ext = {1'b0, opA ^ opB};
            OP_LSH:  ext = {1'b0, opA} << shAmt;
            OP_RSH:  ext = {rshTmp[0], rshTmp[WIDTH:1]};
            OP_CMP: begin
                ext    = {1'b0, opA} - {1'b0, opB};
                resV   = (opA[MSB] != opB[MSB]) && (ext[MSB] != opA[MSB]);
                updCmp = 1'b1;
            end
            default: updNzcv = 1'b0;
        endcase

        nextFlags = flagReg;
        if (updNzcv) begin
            nextFlags[0] = ext[WIDTH];
            nextFlags[1] = (resY == '0);
            nextFlags[5] = resY[MSB];
            nextFlags[6] = resV;
        end
        if (updCmp) begin
            nextFlags[2] = (opA == opB);
            nextFlags[3] = (opA > opB);
            nextFlags[4] = (opA < opB);
        end
    end

`ifdef ARGON_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'hD;
    localparam int         CW     = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mulCand;
    logic [2*WIDTH-1:0] mulAcc;
    logic [WIDTH-1:0]   mulPlier;
    logic [CW-1:0]      mulCnt;

    assign goBusy  = accept && (bus.i_op == OP_MUL);
    assign mulDone = (mulCnt == CW'(WIDTH));
    assign mulY    = mulAcc[MSB:0];
    assign mulHi   = |mulAcc[2*WIDTH-1:WIDTH];

    // One partial product per BUSY cycle; one extra BUSY cycle registers the result.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            mulCand  <= '0;
            mulAcc   <= '0;
            mulPlier <= '0;
            mulCnt   <= '0;
        end else if (goBusy) begin
            mulCand  <= {{WIDTH{1'b0}}, bus.i_a};
            mulAcc   <= '0;
            mulPlier <= bus.i_b;
            mulCnt   <= '0;
        end else if (state == BUSY && !mulDone) begin
            if (mulPlier[0]) mulAcc <= mulAcc + mulCand;
            mulCand  <= mulCand << 1;
            mulPlier <= mulPlier >> 1;
            mulCnt   <= mulCnt + CW'(1);
        end
    end
`else
    assign goBusy  = 1'b0;
    assign mulDone = 1'b0;
    assign mulY    = '0;
    assign mulHi   = 1'b0;
`endif

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state    <= IDLE;
            validReg <= 1'b0;
            yReg     <= '0;
            flagReg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_flags_we) begin
                        flagReg <= bus.i_flags[6:0];
                    end else if (goBusy) begin
                        state <= BUSY;
                    end else if (accept) begin
                        state    <= DONE;
                        validReg <= 1'b1;
                        yReg     <= resY;
                        flagReg  <= nextFlags;
                    end
                end
                BUSY: begin
                    if (mulDone) begin
                        state    <= DONE;
                        validReg <= 1'b1;
                        yReg     <= mulY;
                        flagReg  <= {1'b0, mulY[MSB], flagReg[4:2], (mulY == '0), mulHi};
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        state    <= IDLE;
                        validReg <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_argon_alu_seq.sv
// Bench for argon_alu_seq: directed vector table, multi-cycle hand sequences and
// randomized operations scored against a plain-arithmetic model of the ALU.
module tb_argon_alu_seq;
    localparam int W = 16;
`ifdef ARGON_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] dbgState;

    argon_alu_seq_if #(.WIDTH(W)) bus ();

    argon_alu_seq #(.WIDTH(W)) dut (
        .i_Clk      (clk),
        .i_Reset_n  (rst_n),
        .bus        (bus),
        .o_dbgState (dbgState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0] pre;
        logic [15:0] expY;
        logic [7:0] expF;
        int         expLat;
    } vecT;

    vecT        vecs[$];
    logic [W-1:0] expQ[$];
    logic [7:0] expFQ[$];
    int         nVec;
    int         nErr;
    logic [15:0] gotY;
    logic [7:0] gotF;
    int         lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void addVec(input string name, input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [7:0] pre, input logic [15:0] ey,
                                   input logic [7:0] ef, input int el);
        vecT v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.pre = pre;
        v.expY = ey; v.expF = ef; v.expLat = el;
        vecs.push_back(v);
    endfunction

    // Reference model: plain integer arithmetic over the flag rules.
    function automatic void refModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic [7:0] fin, output logic [15:0] y,
                                     output logic [7:0] fo, output int el);
        longint ua, ub, sa, sb, cin, r, sr;
        int amt;
        logic c, v;
        bit upd;
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        cin = fin[0] ? 1 : 0;
        amt = int'(b) % W;
        y = '0; c = 1'b0; v = 1'b0; upd = 1'b1; el = 1; r = 0; sr = 0;
        fo = {1'b0, fin[6:0]};
        case (op)
            4'd0, 4'd1, 4'd3: begin
                if (op == 4'd3) begin r = ua + 1; sr = sa + 1; end
                else if (op == 4'd1) begin r = ua + ub + cin; sr = sa + sb + cin; end
                else begin r = ua + ub; sr = sa + sb; end
                c = (r >= 65536);
            end
            4'd2, 4'd4, 4'd12: begin
                if (op == 4'd4) begin r = ua - 1; sr = sa - 1; end
                else if (op == 4'd2) begin r = ua - ub - cin; sr = sa - sb - cin; end
                else begin r = ua - ub; sr = sa - sb; end
                c = (r < 0);
            end
            4'd5: y = ~(a & b);
            4'd6: y = a & b;
            4'd7: y = a | b;
            4'd8: y = ~(a | b);
            4'd9: y = a ^ b;
            4'd10: begin
                y = 16'(ua << amt);
                c = (amt == 0) ? 1'b0 : (((ua >> (W - amt)) & 1) != 0);
            end
            4'd11: begin
                y = 16'(ua >> amt);
                c = (amt == 0) ? 1'b0 : (((ua >> (amt - 1)) & 1) != 0);
            end
            4'd13: begin
                if (MUL_EN) begin
                    r = ua * ub;
                    y = 16'(r);
                    c = ((r >> 16) != 0);
                    el = W + 1;
                end else begin
                    upd = 1'b0;
                end
            end
            default: upd = 1'b0;
        endcase
        if (op <= 4'd4 || op == 4'd12) begin
            y = 16'(r);
            v = (sr > 32767) || (sr < -32768);
        end
        if (op == 4'd13 && MUL_EN) y = 16'(r);
        if (upd) begin
            fo[0] = c;
            fo[1] = (y == 16'h0000);
            fo[5] = y[15];
            fo[6] = v;
        end
        if (op == 4'd12) begin
            fo[2] = (a == b);
            fo[3] = (a > b);
            fo[4] = (a < b);
        end
    endfunction

    task automatic writeFlags(input logic [7:0] v);
        @(negedge clk);
        bus.i_flags_we = 1'b1;
        bus.i_flags    = v;
        @(posedge clk);
        #1;
        bus.i_flags_we = 1'b0;
        bus.i_flags    = 8'($urandom);
    endtask

    // Issue one request, scramble the inputs after accept, wait (bounded) for the response.
    task automatic doOp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] y, output logic [7:0] f, output int l);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_op    = 4'($urandom);
        bus.i_a     = 16'($urandom);
        bus.i_b     = 16'($urandom);
        l = 1;
        while (!bus.o_valid && l < 64) begin
            @(posedge clk);
            #1;
            l++;
        end
        y = bus.o_y;
        f = bus.o_flags;
    endtask

    task automatic consume();
        @(negedge clk);
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra, rb, ey;
        logic [7:0]  mflags, ef, fw;
        logic [3:0]  rop;
        int          el;

        nVec = 0;
        nErr = 0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_op = '0; bus.i_a = '0; bus.i_b = '0;
        bus.i_flags_we = 1'b0; bus.i_flags = '0; bus.i_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_y", 32'(bus.o_y), 32'd0);
        check("rst_flags", 32'(bus.o_flags), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);

        addVec("add_wrap",   4'h0, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h03, 1);
        addVec("adc_cin",    4'h1, 16'h0001, 16'h0001, 8'h01, 16'h0003, 8'h00, 1);
        addVec("sbc_zero",   4'h2, 16'h0005, 16'h0005, 8'h00, 16'h0000, 8'h02, 1);
        addVec("sbc_ovf",    4'h2, 16'h8000, 16'h0001, 8'h01, 16'h7FFE, 8'h40, 1);
        addVec("sbc_borrow", 4'h2, 16'h0000, 16'h0000, 8'h01, 16'hFFFF, 8'h21, 1);
        addVec("cmp_lt",     4'hC, 16'h0003, 16'h0007, 8'h00, 16'hFFFC, 8'h31, 1);
        addVec("cmp_eq",     4'hC, 16'h0009, 16'h0009, 8'h00, 16'h0000, 8'h06, 1);
        addVec("cmp_gt",     4'hC, 16'hFFFF, 16'h0001, 8'h00, 16'hFFFE, 8'h28, 1);
        addVec("rsh_1",      4'hB, 16'h8001, 16'h0001, 8'h00, 16'h4000, 8'h01, 1);
        addVec("lsh_amt0",   4'hA, 16'h8001, 16'h0010, 8'h00, 16'h8001, 8'h20, 1);
        addVec("lsh_1",      4'hA, 16'h8001, 16'h0001, 8'h00, 16'h0002, 8'h01, 1);
        addVec("lsh_15",     4'hA, 16'h0001, 16'h000F, 8'h00, 16'h8000, 8'h20, 1);
        addVec("rsh_15",     4'hB, 16'h0003, 16'h000F, 8'h00, 16'h0000, 8'h02, 1);
        addVec("add_ovf",    4'h0, 16'h7FFF, 16'h0001, 8'h1C, 16'h8000, 8'h7C, 1);
        addVec("xor_keep",   4'h9, 16'hAAAA, 16'hAAAA, 8'h7F, 16'h0000, 8'h1E, 1);
        addVec("nand",       4'h5, 16'h00F0, 16'h0F00, 8'h00, 16'hFFFF, 8'h20, 1);
        addVec("and",        4'h6, 16'hF0F0, 16'hFF00, 8'h00, 16'hF000, 8'h20, 1);
        addVec("or",         4'h7, 16'h1200, 16'h0034, 8'h41, 16'h1234, 8'h00, 1);
        addVec("nor",        4'h8, 16'h0000, 16'h0000, 8'h00, 16'hFFFF, 8'h20, 1);
        addVec("dec_zero",   4'h4, 16'h0000, 16'h1234, 8'h00, 16'hFFFF, 8'h21, 1);
        addVec("inc_ovf",    4'h3, 16'h7FFF, 16'h1234, 8'h00, 16'h8000, 8'h60, 1);
        addVec("rsv_e",      4'hE, 16'h1234, 16'h5678, 8'h7F, 16'h0000, 8'h7F, 1);
        addVec("rsv_f",      4'hF, 16'hFFFF, 16'hFFFF, 8'h55, 16'h0000, 8'h55, 1);
`ifdef ARGON_ALU_MUL_EN
        addVec("mul_hi",     4'hD, 16'h0100, 16'h0100, 8'h00, 16'h0000, 8'h03, 17);
        addVec("mul_lo",     4'hD, 16'h0003, 16'hFFFF, 8'h00, 16'hFFFD, 8'h21, 17);
`else
        addVec("mul_rsv",    4'hD, 16'h0100, 16'h0100, 8'h15, 16'h0000, 8'h15, 1);
`endif

        foreach (vecs[i]) begin
            writeFlags(vecs[i].pre | 8'h80);
            check({vecs[i].name, "_pre"}, 32'(bus.o_flags), 32'(vecs[i].pre));
            doOp(vecs[i].op, vecs[i].a, vecs[i].b, gotY, gotF, lat);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].expLat));
            check({vecs[i].name, "_y"}, 32'(gotY), 32'(vecs[i].expY));
            check({vecs[i].name, "_flags"}, 32'(gotF), 32'(vecs[i].expF));
            consume();
            check({vecs[i].name, "_done"}, 32'(bus.o_valid), 32'd0);
        end

        // A flag write in IDLE blocks a simultaneous request.
        @(negedge clk);
        bus.i_flags_we = 1'b1; bus.i_flags = 8'h01;
        bus.i_valid = 1'b1; bus.i_op = 4'h0; bus.i_a = 16'h0001; bus.i_b = 16'h0001;
        #1;
        check("fw_ready", 32'(bus.o_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0; bus.i_flags_we = 1'b0;
        check("fw_noaccept", 32'(bus.o_valid), 32'd0);
        check("fw_flags", 32'(bus.o_flags), 32'h01);

        // Held response: outputs stable, no accept, flag writes ignored while DONE.
        writeFlags(8'h00);
        doOp(4'hC, 16'h0003, 16'h0007, gotY, gotF, lat);
        check("hold_lat", 32'(lat), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b1; bus.i_op = 4'h0; bus.i_a = 16'h1111; bus.i_b = 16'h2222;
            bus.i_flags_we = (k % 2 == 0); bus.i_flags = 8'h7F;
            @(posedge clk);
            #1;
            check("hold_valid", 32'(bus.o_valid), 32'd1);
            check("hold_y", 32'(bus.o_y), 32'hFFFC);
            check("hold_flags", 32'(bus.o_flags), 32'h31);
            check("hold_ready", 32'(bus.o_ready), 32'd0);
        end
        @(negedge clk);
        bus.i_valid = 1'b0; bus.i_flags_we = 1'b0;
        consume();
        check("hold_release", 32'(bus.o_valid), 32'd0);
        check("hold_flags_after", 32'(bus.o_flags), 32'h31);

        // Reset while an operation is in flight aborts it.
        writeFlags(8'h7F);
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_op = MUL_EN ? 4'hD : 4'hC;
        bus.i_a = 16'h0100; bus.i_b = 16'h0100;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("arst_valid", 32'(bus.o_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_flags", 32'(bus.o_flags), 32'h00);
        check("arst_ready", 32'(bus.o_ready), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("arst_noresult", 32'(bus.o_valid), 32'd0);
        doOp(4'h0, 16'h0001, 16'h0002, gotY, gotF, lat);
        check("arst_add_lat", 32'(lat), 32'd1);
        check("arst_add_y", 32'(gotY), 32'h0003);
        check("arst_add_flags", 32'(gotF), 32'h00);
        consume();

        // Randomized operations against the model.
        mflags = 8'h00;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                fw = 8'($urandom);
                writeFlags(fw);
                mflags = {1'b0, fw[6:0]};
            end
            rop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: ra = 16'h0000;
                1: ra = 16'hFFFF;
                2: ra = 16'h7FFF;
                3: ra = 16'h8000;
                default: ra = 16'($urandom);
            endcase
            rb = ($urandom_range(0, 4) == 0) ? ra : 16'($urandom);
            refModel(rop, ra, rb, mflags, ey, ef, el);
            expQ.push_back(ey);
            expFQ.push_back(ef);
            doOp(rop, ra, rb, gotY, gotF, lat);
            check("rnd_lat", 32'(lat), 32'(el));
            check("rnd_y", 32'(gotY), 32'(expQ.pop_front()));
            check("rnd_flags", 32'(gotF), 32'(expFQ.pop_front()));
            consume();
            mflags = ef;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
